id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the dual-lane core, with integrated load-use hazard detection. It latches lane 1 (ALU) and lane 2 (load/store) decode fields each cycle and drives the `ID_EX_*` fields consumed by the forwarding unit and the execute-stage operand muxes. When a lane-2 load in EX feeds a source of the instruction in decode, the block stalls fetch/decode and injects bubbles. It also supports branch flush and external hold.

## Interface
Parameters:
- `DATA_W`, 16: operand width.
- `LOAD_LAT`, 1: bubbles inserted per load-use hazard, legal range 1..4.

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch redirect; kills the decode instruction.
- `hold`  in  1  external freeze, e.g. memory busy.
- `id_rm_1`, `id_rd_11`, `id_rd_12`, `id_rd_1`  in  3 each  lane-1 source A, source B (reg form), source B (alt form), destination.
- `id_ALUSrcB`  in  1  selects `id_rd_12` (1) or `id_rd_11` (0) as lane-1 B source.
- `id_RegWrite1`  in  1  lane-1 write enable.
- `id_alu_op_1`  in  4  ALU op.
- `id_rm_2`, `id_rn_2`, `id_rd_2`  in  3 each  lane-2 base, offset, data/destination.
- `id_RegWrite2`, `id_MemRead2`, `id_MemWrite2`  in  1 each  lane-2 controls.
- `id_op1_a`, `id_op1_b`, `id_op2_a`, `id_op2_b`  in  DATA_W each  register-file read data.
- `ID_EX_*`  out  same widths as the matching `id_*` inputs  registered copies of every input above.
- `ID_EX_valid_1`, `ID_EX_valid_2`  out  1  the lane holds a real instruction.
- `stall_if`  out  1  hold PC and the IF/ID register this cycle.

## Operation
- Register 3'b000 is "none". It never matches a hazard compare.
- Lane-1 B source: `id_ALUSrcB ? id_rd_12 : id_rd_11`.
- Hazard condition `haz`: all of the following hold:
  - `ID_EX_MemRead2 & ID_EX_valid_2`;
  - `ID_EX_rd_2 != 0`;
  - `ID_EX_rd_2` equals any of: `id_rm_1`, the lane-1 B source, `id_rm_2`, `id_rn_2`, or `id_rd_2` when `id_MemWrite2`.
- States: RUN, BUBBLE. The block has a bubble counter `cnt`, 3 bits wide.
- Bubble definition: all `ID_EX_*` control bits = 0 (`RegWrite1/2`, `MemRead2`, `MemWrite2`), `valid_1/2` = 0. Register fields and data fields = 0.
- Priority per edge: flush > hold > hazard/bubble > normal load.
  - `flush`: ID/EX ← bubble; state ← RUN; `cnt` ← 0.
  - `hold` (no flush): all registers and state unchanged. `stall_if` = 1.
  - RUN with `haz`: ID/EX ← bubble. If `LOAD_LAT == 1`, stay in RUN. Otherwise go to BUBBLE with `cnt` ← `LOAD_LAT-1`.
  - BUBBLE: ID/EX ← bubble; `cnt` ← `cnt-1`. When `cnt == 1`, next state is RUN.
  - RUN without `haz`: ID/EX ← `id_*` fields; `valid_1/2` ← 1.
- `stall_if` (combinational) = `hold | (state==RUN & haz & !flush) | (state==BUBBLE & !flush)`.
- In BUBBLE, `haz` is not re-evaluated. The decode instruction is already known dependent.

## Timing
- Reset (async, while `reset_n`=0):
  - every `ID_EX_*` output = 0;
  - `valid_1/2` = 0;
  - state = RUN, `cnt` = 0;
  - `stall_if` = 0, given `hold` = 0.
- Latency: `id_*` appears on `ID_EX_*` one cycle after the edge that captures it.
- A load-use hazard costs exactly `LOAD_LAT` cycles of `stall_if`. It inserts exactly `LOAD_LAT` bubbles. The dependent instruction enters ID/EX on the following edge.
- `flush` during BUBBLE aborts the stall. `stall_if` drops in that same cycle, and no further bubbles are inserted.
- `hold` during BUBBLE freezes `cnt`. The stall resumes after `hold` drops, and the bubble count is unchanged.
- `flush` and `hold` together: flush wins.
- `reset_n` asserted mid-stall: everything returns to its reset values immediately.

## Test plan
- Reset then clear: assert `reset_n`=0 mid-run, then release with `hold`/`flush` = 0. Required: all `ID_EX_*` = 0, `valid` = 0, `stall_if` = 0. First edge after release loads `id_*` unchanged.
- Load-use, `LOAD_LAT`=1:
  - stimulus: ID/EX holds load, `rd_2`=3; decode has `id_rm_1`=3;
  - required: `stall_if`=1 for 1 cycle, one bubble. The dependent op appears in ID/EX with `valid_1`=1 on the 2nd edge.
- Load-use, `LOAD_LAT`=3, `id_ALUSrcB`=1, `id_rd_12`=5, load `rd_2`=5. Required: 3 stall cycles, 3 consecutive bubbles, then the instruction loads.
- No false hazard:
  - case 1: load `rd_2`=0 with `id_rm_1`=0 → no stall;
  - case 2: load `rd_2`=4, `id_rd_11`=4, `ALUSrcB`=1, `rd_12`=2 → no stall.
- Flush during BUBBLE (`LOAD_LAT`=3): assert `flush` in the 2nd stall cycle. Required: `stall_if`=0 that cycle, ID/EX = bubble, state = RUN. The next decode instruction loads on the following edge.
- Hold during BUBBLE: 2-cycle `hold` in the 1st BUBBLE cycle. Required: ID/EX and `cnt` frozen, `stall_if`=1 throughout. Total stall = `LOAD_LAT` + 2 cycles.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the dual-lane core.
// It also detects load-use hazards against a lane-2 load in EX and inserts LOAD_LAT bubbles.
module id_ex_stage #(
    parameter int DATA_W   = 16,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              hold,
    input  logic [2:0]        id_rm_1,
    input  logic [2:0]        id_rd_11,
    input  logic [2:0]        id_rd_12,
    input  logic [2:0]        id_rd_1,
    input  logic              id_ALUSrcB,
    input  logic              id_RegWrite1,
    input  logic [3:0]        id_alu_op_1,
    input  logic [2:0]        id_rm_2,
    input  logic [2:0]        id_rn_2,
    input  logic [2:0]        id_rd_2,
    input  logic              id_RegWrite2,
    input  logic              id_MemRead2,
    input  logic              id_MemWrite2,
    input  logic [DATA_W-1:0] id_op1_a,
    input  logic [DATA_W-1:0] id_op1_b,
    input  logic [DATA_W-1:0] id_op2_a,
    input  logic [DATA_W-1:0] id_op2_b,
    output logic [2:0]        ID_EX_rm_1,
    output logic [2:0]        ID_EX_rd_11,
    output logic [2:0]        ID_EX_rd_12,
    output logic [2:0]        ID_EX_rd_1,
    output logic              ID_EX_ALUSrcB,
    output logic              ID_EX_RegWrite1,
    output logic [3:0]        ID_EX_alu_op_1,
    output logic [2:0]        ID_EX_rm_2,
    output logic [2:0]        ID_EX_rn_2,
    output logic [2:0]        ID_EX_rd_2,
    output logic              ID_EX_RegWrite2,
    output logic              ID_EX_MemRead2,
    output logic              ID_EX_MemWrite2,
    output logic [DATA_W-1:0] ID_EX_op1_a,
    output logic [DATA_W-1:0] ID_EX_op1_b,
    output logic [DATA_W-1:0] ID_EX_op2_a,
    output logic [DATA_W-1:0] ID_EX_op2_b,
    output logic              ID_EX_valid_1,
    output logic              ID_EX_valid_2,
    output logic              stall_if
);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [2:0] src_b_1;
    logic       haz;
    logic       do_bubble;
    logic       do_load;

    assign src_b_1 = id_ALUSrcB ? id_rd_12 : id_rd_11;

    // Register 0 is "none", so a load targeting it never creates a dependency.
    always_comb begin
        haz = ID_EX_MemRead2 && ID_EX_valid_2 && (ID_EX_rd_2 != 3'd0) &&
              ((ID_EX_rd_2 == id_rm_1) || (ID_EX_rd_2 == src_b_1) ||
               (ID_EX_rd_2 == id_rm_2) || (ID_EX_rd_2 == id_rn_2) ||
               (id_MemWrite2 && (ID_EX_rd_2 == id_rd_2)));
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_bubble  = 1'b0;
        do_load    = 1'b0;
        if (flush) begin
            do_bubble  = 1'b1;
            state_next = RUN;
            cnt_next   = 3'd0;
        end else if (hold) begin
            state_next = state_reg;
        end else if (state_reg == RUN) begin
            if (haz) begin
                do_bubble = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_next = BUBBLE;
                    cnt_next   = 3'(LOAD_LAT - 1);
                end
            end else begin
                do_load = 1'b1;
            end
        end else begin
            // Decode is already known dependent here; haz is not re-checked.
            do_bubble = 1'b1;
            cnt_next  = cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
                state_next = RUN;
            end
        end
    end

    assign stall_if = hold || ((state_reg == RUN) && haz && !flush) ||
                      ((state_reg == BUBBLE) && !flush);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || do_bubble) begin
            ID_EX_rm_1      <= '0;
            ID_EX_rd_11     <= '0;
            ID_EX_rd_12     <= '0;
            ID_EX_rd_1      <= '0;
            ID_EX_ALUSrcB   <= 1'b0;
            ID_EX_RegWrite1 <= 1'b0;
            ID_EX_alu_op_1  <= '0;
            ID_EX_rm_2      <= '0;
            ID_EX_rn_2      <= '0;
            ID_EX_rd_2      <= '0;
            ID_EX_RegWrite2 <= 1'b0;
            ID_EX_MemRead2  <= 1'b0;
            ID_EX_MemWrite2 <= 1'b0;
            ID_EX_op1_a     <= '0;
            ID_EX_op1_b     <= '0;
            ID_EX_op2_a     <= '0;
            ID_EX_op2_b     <= '0;
            ID_EX_valid_1   <= 1'b0;
            ID_EX_valid_2   <= 1'b0;
        end else if (do_load) begin
            ID_EX_rm_1      <= id_rm_1;
            ID_EX_rd_11     <= id_rd_11;
            ID_EX_rd_12     <= id_rd_12;
            ID_EX_rd_1      <= id_rd_1;
            ID_EX_ALUSrcB   <= id_ALUSrcB;
            ID_EX_RegWrite1 <= id_RegWrite1;
            ID_EX_alu_op_1  <= id_alu_op_1;
            ID_EX_rm_2      <= id_rm_2;
            ID_EX_rn_2      <= id_rn_2;
            ID_EX_rd_2      <= id_rd_2;
            ID_EX_RegWrite2 <= id_RegWrite2;
            ID_EX_MemRead2  <= id_MemRead2;
            ID_EX_MemWrite2 <= id_MemWrite2;
            ID_EX_op1_a     <= id_op1_a;
            ID_EX_op1_b     <= id_op1_b;
            ID_EX_op2_a     <= id_op2_a;
            ID_EX_op2_b     <= id_op2_b;
            ID_EX_valid_1   <= 1'b1;
            ID_EX_valid_2   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: LOAD_LAT=1 and LOAD_LAT=3 instances share one decode stream and are
// checked against a remaining-bubble-count model, a directed vector table and random traffic.
module tb_id_ex_stage;

    localparam int DW = 16;

    typedef struct packed {
        logic [2:0]    rm_1;
        logic [2:0]    rd_11;
        logic [2:0]    rd_12;
        logic [2:0]    rd_1;
        logic          ALUSrcB;
        logic          RegWrite1;
        logic [3:0]    alu_op_1;
        logic [2:0]    rm_2;
        logic [2:0]    rn_2;
        logic [2:0]    rd_2;
        logic          RegWrite2;
        logic          MemRead2;
        logic          MemWrite2;
        logic [DW-1:0] op1_a;
        logic [DW-1:0] op1_b;
        logic [DW-1:0] op2_a;
        logic [DW-1:0] op2_b;
    } dec_t;

    typedef struct packed {
        dec_t d;
        logic v1;
        logic v2;
    } out_t;

    typedef struct {
        dec_t       d;
        logic       fl;
        logic       ho;
        logic [1:0] st;   // {stall of LOAD_LAT=3, stall of LOAD_LAT=1}
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       hold;
    dec_t       din;
    out_t       act [2];
    logic [1:0] stall_v;

    int   lat [2] = '{1, 3};
    out_t mexp [2];
    int   mleft [2];
    int   n_chk;
    int   n_fail;
    vec_t tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [2:0]    rm_1, rd_11, rd_12, rd_1, rm_2, rn_2, rd_2;
        logic          alusrcb, regwrite1, regwrite2, memread2, memwrite2, valid_1, valid_2, stall;
        logic [3:0]    alu_op_1;
        logic [DW-1:0] op1_a, op1_b, op2_a, op2_b;

        id_ex_stage #(.DATA_W(DW), .LOAD_LAT(LAT)) u_dut (
            .clk(clk), .reset_n(reset_n), .flush(flush), .hold(hold),
            .id_rm_1(din.rm_1), .id_rd_11(din.rd_11), .id_rd_12(din.rd_12), .id_rd_1(din.rd_1),
            .id_ALUSrcB(din.ALUSrcB), .id_RegWrite1(din.RegWrite1), .id_alu_op_1(din.alu_op_1),
            .id_rm_2(din.rm_2), .id_rn_2(din.rn_2), .id_rd_2(din.rd_2),
            .id_RegWrite2(din.RegWrite2), .id_MemRead2(din.MemRead2), .id_MemWrite2(din.MemWrite2),
            .id_op1_a(din.op1_a), .id_op1_b(din.op1_b), .id_op2_a(din.op2_a), .id_op2_b(din.op2_b),
            .ID_EX_rm_1(rm_1), .ID_EX_rd_11(rd_11), .ID_EX_rd_12(rd_12), .ID_EX_rd_1(rd_1),
            .ID_EX_ALUSrcB(alusrcb), .ID_EX_RegWrite1(regwrite1), .ID_EX_alu_op_1(alu_op_1),
            .ID_EX_rm_2(rm_2), .ID_EX_rn_2(rn_2), .ID_EX_rd_2(rd_2),
            .ID_EX_RegWrite2(regwrite2), .ID_EX_MemRead2(memread2), .ID_EX_MemWrite2(memwrite2),
            .ID_EX_op1_a(op1_a), .ID_EX_op1_b(op1_b), .ID_EX_op2_a(op2_a), .ID_EX_op2_b(op2_b),
            .ID_EX_valid_1(valid_1), .ID_EX_valid_2(valid_2), .stall_if(stall)
        );

        assign act[gi] = {rm_1, rd_11, rd_12, rd_1, alusrcb, regwrite1, alu_op_1, rm_2, rn_2, rd_2,
                          regwrite2, memread2, memwrite2, op1_a, op1_b, op2_a, op2_b, valid_1, valid_2};
        assign stall_v[gi] = stall;
    end

    // Reference model: an in-flight load in EX, a decode instruction, and bubbles still owed.
    function automatic logic model_haz(input out_t e, input dec_t d);
        logic [2:0] b;
        b = d.ALUSrcB ? d.rd_12 : d.rd_11;
        return e.d.MemRead2 && e.v2 && (e.d.rd_2 != 3'd0) &&
               (e.d.rd_2 == d.rm_1 || e.d.rd_2 == b || e.d.rd_2 == d.rm_2 ||
                e.d.rd_2 == d.rn_2 || (d.MemWrite2 && e.d.rd_2 == d.rd_2));
    endfunction

    function automatic logic exp_stall(input int k);
        if (hold) return 1'b1;
        if (flush) return 1'b0;
        return (mleft[k] > 0) || model_haz(mexp[k], din);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mexp[k]  = '0;
            mleft[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                mexp[k]  = '0;
                mleft[k] = 0;
            end else if (hold) begin
                mleft[k] = mleft[k];
            end else if (mleft[k] > 0) begin
                mexp[k]  = '0;
                mleft[k] = mleft[k] - 1;
            end else if (model_haz(mexp[k], din)) begin
                mexp[k]  = '0;
                mleft[k] = lat[k] - 1;
            end else begin
                mexp[k] = {din, 1'b1, 1'b1};
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] want, input bit use_tbl);
        for (int k = 0; k < 2; k++) begin
            logic es;
            es = exp_stall(k);
            n_chk++;
            if (act[k] !== mexp[k]) begin
                n_fail++;
                $display("FAIL %s lat%0d id_ex: got %h required %h", tag, lat[k], act[k], mexp[k]);
            end
            n_chk++;
            if (stall_v[k] !== es) begin
                n_fail++;
                $display("FAIL %s lat%0d stall_if: got %b required %b", tag, lat[k], stall_v[k], es);
            end
            if (use_tbl) begin
                n_chk++;
                if (stall_v[k] !== want[k]) begin
                    n_fail++;
                    $display("FAIL %s lat%0d stall_if(table): got %b required %b",
                             tag, lat[k], stall_v[k], want[k]);
                end
            end
        end
    endtask

    task automatic step(input dec_t d, input logic fl, input logic ho, input string tag,
                        input logic [1:0] want, input bit use_tbl);
        din   = d;
        flush = fl;
        hold  = ho;
        #1;
        check(tag, want, use_tbl);
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
    endtask

    function automatic dec_t ld(input logic [2:0] rd);
        dec_t d;
        d = '0;
        d.rm_2 = 3'd7;  d.rn_2 = 3'd6;  d.rd_2 = rd;
        d.MemRead2 = 1'b1;  d.RegWrite2 = 1'b1;
        d.op2_a = 16'h1000 + 16'(rd);  d.op2_b = 16'h0042;
        return d;
    endfunction

    function automatic dec_t st(input logic [2:0] rd);
        dec_t d;
        d = '0;
        d.rm_2 = 3'd7;  d.rn_2 = 3'd6;  d.rd_2 = rd;
        d.MemWrite2 = 1'b1;
        d.op2_a = 16'h2000;  d.op2_b = 16'h0004;
        return d;
    endfunction

    function automatic dec_t alu(input logic [2:0] rm1, input logic [2:0] rd11,
                                 input logic [2:0] rd12, input logic srcb);
        dec_t d;
        d = '0;
        d.rm_1 = rm1;  d.rd_11 = rd11;  d.rd_12 = rd12;  d.ALUSrcB = srcb;
        d.rd_1 = 3'd1;  d.RegWrite1 = 1'b1;  d.alu_op_1 = 4'h5;
        d.op1_a = 16'hA000 ^ 16'(rm1);  d.op1_b = 16'h5A5A;
        return d;
    endfunction

    function automatic dec_t rand_dec();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[93:0];
    endfunction

    task automatic add(input dec_t d, input logic fl, input logic ho, input logic [1:0] s);
        vec_t v;
        v.d = d;  v.fl = fl;  v.ho = ho;  v.st = s;
        tbl.push_back(v);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        hold    = 1'b0;
        din     = '0;
        model_reset();

        // Load-use, rm_1 source
        add(ld(3), 0, 0, 2'b00);  add(alu(3, 0, 0, 0), 0, 0, 2'b11);
        add(alu(3, 0, 0, 0), 0, 0, 2'b10);  add(alu(3, 0, 0, 0), 0, 0, 2'b10);
        add(alu(3, 0, 0, 0), 0, 0, 2'b00);
        // Load-use through the alt B source
        add(ld(5), 0, 0, 2'b00);  add(alu(1, 2, 5, 1), 0, 0, 2'b11);
        add(alu(1, 2, 5, 1), 0, 0, 2'b10);  add(alu(1, 2, 5, 1), 0, 0, 2'b10);
        add(alu(1, 2, 5, 1), 0, 0, 2'b00);
        // No false hazards
        add(ld(0), 0, 0, 2'b00);  add(alu(0, 0, 0, 0), 0, 0, 2'b00);
        add(ld(4), 0, 0, 2'b00);  add(alu(1, 4, 2, 1), 0, 0, 2'b00);
        // Flush in the second stall cycle
        add(ld(3), 0, 0, 2'b00);  add(alu(3, 0, 0, 0), 0, 0, 2'b11);
        add(alu(3, 0, 0, 0), 1, 0, 2'b00);  add(alu(3, 0, 0, 0), 0, 0, 2'b00);
        // Two-cycle hold in the first bubble cycle
        add(ld(3), 0, 0, 2'b00);  add(alu(3, 0, 0, 0), 0, 0, 2'b11);
        add(alu(3, 0, 0, 0), 0, 1, 2'b11);  add(alu(3, 0, 0, 0), 0, 1, 2'b11);
        add(alu(3, 0, 0, 0), 0, 0, 2'b10);  add(alu(3, 0, 0, 0), 0, 0, 2'b10);
        add(alu(3, 0, 0, 0), 0, 0, 2'b00);
        // Flush and hold together, then a store whose data register is the load target
        add(ld(3), 0, 0, 2'b00);  add(alu(3, 0, 0, 0), 1, 1, 2'b11);
        add(alu(3, 0, 0, 0), 0, 0, 2'b00);
        add(ld(2), 0, 0, 2'b00);  add(st(2), 0, 0, 2'b11);
        add(st(2), 0, 0, 2'b10);  add(st(2), 0, 0, 2'b10);  add(st(2), 0, 0, 2'b00);

        repeat (2) @(negedge clk);
        step('0, 0, 0, "reset", 2'b00, 1);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            $display("vec %0d: rm_1=%0d rd_2=%0d mr=%0b mw=%0b flush=%0b hold=%0b stall_if=%b",
                     i, tbl[i].d.rm_1, tbl[i].d.rd_2, tbl[i].d.MemRead2, tbl[i].d.MemWrite2,
                     tbl[i].fl, tbl[i].ho, stall_v);
            step(tbl[i].d, tbl[i].fl, tbl[i].ho, $sformatf("vec%0d", i), tbl[i].st, 1);
        end

        // Reset asserted mid-stall
        step(ld(3), 0, 0, "mid_ld", 2'b00, 1);
        step(alu(3, 0, 0, 0), 0, 0, "mid_use", 2'b11, 1);
        reset_n = 1'b0;
        model_reset();
        step(alu(3, 0, 0, 0), 0, 0, "mid_reset", 2'b00, 1);
        reset_n = 1'b1;
        step(alu(3, 0, 0, 0), 0, 0, "after_reset", 2'b00, 1);
        step(alu(3, 0, 0, 0), 0, 0, "after_reset_load", 2'b00, 1);

        for (int i = 0; i < 600; i++) begin
            dec_t d;
            logic fl, ho;
            d  = rand_dec();
            fl = ($urandom_range(0, 15) == 0);
            ho = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                model_reset();
                step(d, 1'b0, 1'b0, "rand_reset", 2'b00, 0);
                reset_n = 1'b1;
            end else begin
                step(d, fl, ho, $sformatf("rand%0d", i), 2'b00, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
